logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit gate primitives.
- Applies one of eight bitwise logic operations to WIDTH-bit operands under a valid/ready handshake, with a 2-stage pipeline and result flags.
- Sits between operand sources (register file / test stimulus) and downstream consumers in the building-blocks library.

Parameters:
- WIDTH, 8, operand/result bit width (>=1).
- OPW, 3, opcode width (fixed at 3; exposed for package consistency).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  OPW  opcode.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- out_res  output  WIDTH  result.
- out_zero  output  1  out_res == 0.
- out_par  output  1  XOR-reduction of out_res.
- Interface rule: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Opcodes:
  - 0 AND a&b
  - 1 OR a|b
  - 2 NOT ~a (b ignored)
  - 3 NAND ~(a&b)
  - 4 NOR ~(a|b)
  - 5 XOR a^b
  - 6 XNOR ~(a^b)
  - 7 PASS_B b
- All results are exactly WIDTH bits; no carries or extension.
- Stage 1 (S1): registers a, b, op and s1_v.
- Stage 2 (S2): registers the computed result, zero and parity, and s2_v.
  - Flags are computed from the same result that is registered, so they are always coherent with out_res.
- Advance rules:
  - s2_adv = !s2_v | out_ready.
  - s1_adv = !s1_v | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output transferred when out_valid & out_ready.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later if out_ready held high.
- Throughput: 1 beat/cycle with out_ready high.
- Backpressure (out_ready=0 with both stages full):
  - in_ready=0.
  - out_res/out_zero/out_par and S1 contents held stable.
  - No beat dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal; the pipeline shifts.
- When a stage is not advancing, its data registers hold. When a stage holds no valid beat, its data registers may still load (don't-care), but out_valid must be 0.
- Reset (async assert, sync-style deassert on next edge):
  - s1_v=0, s2_v=0, out_valid=0.
  - out_res=0, out_zero=1, out_par=0.
  - Mid-operation reset discards in-flight beats.
  - in_ready=1 in the first cycle after reset release.
- in_a/in_b/in_op are sampled only on accept; changes while in_ready=0 have no effect.

Optional Feature:
- Macro LOGIC_UNIT_CNT_EN.
- Defined:
  - Adds output port out_cnt (16 bits), counting completed output transfers (out_valid & out_ready).
  - Reset to 0; wraps 0xFFFF->0.
- Undefined: port and counter absent; no other behavioural change.

Decomposition:
- Package logic_unit_pkg:
  - OPW constant.
  - Opcode enum/localparams (OP_AND..OP_PASSB).
  - CNT_W=16.
- Sub-module logic_unit_core: purely combinational WIDTH-parametrised op decode producing res, zero, par. Instantiated once between S1 and S2.

Test Plan (WIDTH=8):
- Reset: assert rst mid-stream with 2 beats in flight -> out_valid=0, out_res=0x00, out_zero=1, in_ready=1 after release; no stale beat emitted.
- All ops, out_ready=1: a=0xA5, b=0x3C, op 0..7 on consecutive cycles -> results 0x24, 0xBD, 0x5A, 0xDB, 0x42, 0x99, 0x66, 0x3C, each 2 cycles after accept, one per cycle.
- Flags: op0 a=0xF0 b=0x0F -> out_res=0x00, zero=1, par=0. Op7 b=0x07 -> zero=0, par=1.
- Backpressure: stream 5 beats, drop out_ready for 4 cycles after the first output -> in_ready falls within a cycle once both stages are full, outputs held stable, all 5 results delivered in order with no loss or duplication.
- Bubbles: in_valid toggling 1,0,1,0 with out_ready=1 -> out_valid pattern 1,0,1,0 delayed by 2 cycles.
- LOGIC_UNIT_CNT_EN: 300 transfers -> out_cnt=300. Force the count to 0xFFFF, then 1 transfer -> out_cnt=0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared constants and opcode encoding for the pipelined logic unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package logic_unit_pkg;

  localparam int OPW   = 3;
  localparam int CNT_W = 16;

  typedef enum logic [OPW-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOT   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XOR   = 3'd5,
    OP_XNOR  = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise op decode with zero/parity flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline owns flow control.
//
// Ports:
//   a, b  : WIDTH-bit operands (b unused for OP_NOT)
//   op    : opcode (logic_unit_pkg::op_e encoding)
//   res   : WIDTH-bit result, no carries or extension
//   zero  : res == 0
//   par   : XOR-reduction of res
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             par
);

  always_comb begin
    res = '0;
    case (op)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_NOT:   res = ~a;
      OP_NAND:  res = ~(a & b);
      OP_NOR:   res = ~(a | b);
      OP_XOR:   res = a ^ b;
      OP_XNOR:  res = ~(a ^ b);
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
  end

  // Flags derive from the exact value that gets registered, so they can
  // never disagree with the result they describe.
  assign zero = ~|res;
  assign par  = ^res;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with zero/parity result flags.
// Latency: 2 cycles from accept to out_valid; 1 beat/cycle throughput.
// Backpressure: out_ready low stalls S2, then S1; in_ready drops combinationally (no skid).
//
// Ports:
//   clk, rst                    : clock (rising edge), async active-high reset
//   in_valid/in_ready           : operand handshake; in_a, in_b, in_op sampled on accept
//   out_valid/out_ready         : result handshake; out_res, out_zero, out_par
//   out_cnt (LOGIC_UNIT_CNT_EN) : 16-bit wrapping count of completed output transfers
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_par
`ifdef LOGIC_UNIT_CNT_EN
  ,
  output logic [logic_unit_pkg::CNT_W-1:0] out_cnt
`endif
);

  // Stage 1 state
  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;

  // Stage 2 state
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             par_q, par_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] core_res;
  logic             core_zero, core_par;

  // A stage may advance when it is empty or its downstream is advancing.
  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .res  (core_res),
    .zero (core_zero),
    .par  (core_par)
  );

  always_comb begin
    s1_v_d = s1_v_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    if (s1_adv) begin
      s1_v_d = in_valid;
    end
    // Operands load only on a real accept so idle toggling on the inputs
    // leaves the stage registers quiet.
    if (in_valid && s1_adv) begin
      a_d  = in_a;
      b_d  = in_b;
      op_d = in_op;
    end
  end

  always_comb begin
    s2_v_d = s2_v_q;
    res_d  = res_q;
    zero_d = zero_q;
    par_d  = par_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
    end
    if (s2_adv && s1_v_q) begin
      res_d  = core_res;
      zero_d = core_zero;
      par_d  = core_par;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      s2_v_q <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b1;
      par_q  <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      s2_v_q <= s2_v_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      par_q  <= par_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_res   = res_q;
  assign out_zero  = zero_q;
  assign out_par   = par_q;

`ifdef LOGIC_UNIT_CNT_EN
  logic [logic_unit_pkg::CNT_W-1:0] cnt_q, cnt_d;

  // Free-running wrap at the counter width is intended.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_v_q && out_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8).
// Latency: n/a.
// Backpressure: exercised by driving out_ready low for a stall window.
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_zero;
  logic         out_par;
`ifdef LOGIC_UNIT_CNT_EN
  logic [15:0]  out_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] got_q[$];

  logic_unit_pipe #(
    .WIDTH (W),
    .OPW   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_par   (out_par)
`ifdef LOGIC_UNIT_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Record every completed transfer; sampled mid-cycle when inputs are settled.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_res);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    logic [W-1:0] ops_exp [8];
    logic [W-1:0] bp_exp  [5];
    int           idx;
    logic         acc;
    logic         exp_v;

    ops_exp = '{8'h24, 8'hBD, 8'h5A, 8'hDB, 8'h42, 8'h99, 8'h66, 8'h3C};
    bp_exp  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_res",   32'(out_res),   32'h00);
    check_eq("rst_out_zero",  32'(out_zero),  32'd1);
    check_eq("rst_out_par",   32'(out_par),   32'd0);
    rst = 1'b0;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef LOGIC_UNIT_CNT_EN
    check_eq("rst_out_cnt",   32'(out_cnt),   32'd0);
`endif

    // ---------------- all ops back to back ----------------
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      in_a     = 8'hA5;
      in_b     = 8'h3C;
      in_op    = 3'(i);
      tick();
      if (i == 0 || i == 9) begin
        check_eq($sformatf("ops_idle_valid_%0d", i), 32'(out_valid), 32'd0);
      end else begin
        check_eq($sformatf("ops_valid_%0d", i - 1), 32'(out_valid), 32'd1);
        check_eq($sformatf("ops_res_%0d", i - 1),   32'(out_res),   32'(ops_exp[i-1]));
        check_eq($sformatf("ops_par_%0d", i - 1),   32'(out_par),   32'(^ops_exp[i-1]));
      end
    end
    idle(2);

    // ---------------- flags ----------------
    in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h0F; in_op = 3'd0;
    tick();
    in_a = 8'h00; in_b = 8'h07; in_op = 3'd7;
    tick();
    in_valid = 1'b0;
    check_eq("flag0_valid", 32'(out_valid), 32'd1);
    check_eq("flag0_res",   32'(out_res),   32'h00);
    check_eq("flag0_zero",  32'(out_zero),  32'd1);
    check_eq("flag0_par",   32'(out_par),   32'd0);
    tick();
    check_eq("flag7_res",   32'(out_res),   32'h07);
    check_eq("flag7_zero",  32'(out_zero),  32'd0);
    check_eq("flag7_par",   32'(out_par),   32'd1);
    idle(2);

    // ---------------- backpressure ----------------
    got_q.delete();
    idx = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (idx < 5);
      in_a      = (idx < 5) ? bp_exp[idx] : 8'h00;
      in_b      = 8'h00;
      in_op     = 3'd1;
      #1;
      if (cyc >= 3 && cyc <= 6) begin
        check_eq($sformatf("bp_in_ready_c%0d", cyc),  32'(in_ready),  32'd0);
        check_eq($sformatf("bp_out_valid_c%0d", cyc), 32'(out_valid), 32'd1);
        check_eq($sformatf("bp_out_hold_c%0d", cyc),  32'(out_res),   32'h22);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_accepted", 32'(idx), 32'd5);
    check_eq("bp_delivered", 32'(got_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got_q.size())
        check_eq($sformatf("bp_order_%0d", k), 32'(got_q[k]), 32'(bp_exp[k]));
      else
        check_eq($sformatf("bp_missing_%0d", k), 32'hDEAD, 32'(bp_exp[k]));
    end
    idle(2);

    // ---------------- bubbles ----------------
    for (int i = 0; i < 6; i++) begin
      in_valid = (i == 0 || i == 2);
      in_a = 8'h5A; in_b = 8'h00; in_op = 3'd1;
      tick();
      exp_v = (i == 1 || i == 3);
      check_eq($sformatf("bub_valid_%0d", i), 32'(out_valid), 32'(exp_v));
    end
    idle(2);

    // ---------------- reset with two beats in flight ----------------
    got_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h00; in_b = 8'h77; in_op = 3'd7;
    tick();
    in_b = 8'h88;
    tick();
    in_valid = 1'b0;
    check_eq("mid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_res",   32'(out_res),   32'h00);
    check_eq("mid_rst_zero",  32'(out_zero),  32'd1);
    check_eq("mid_rst_par",   32'(out_par),   32'd0);
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("mid_no_stale_%0d", i), 32'(out_valid), 32'd0);
    end
    check_eq("mid_no_emit", 32'(got_q.size()), 32'd0);

`ifdef LOGIC_UNIT_CNT_EN
    // ---------------- transfer counter ----------------
    check_eq("cnt_after_rst", 32'(out_cnt), 32'd0);
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02; in_op = 3'd5;
    repeat (300) tick();
    idle(3);
    check_eq("cnt_300", 32'(out_cnt), 32'd300);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    check_eq("cnt_forced", 32'(out_cnt), 32'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("cnt_wrap", 32'(out_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
